// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: round-robin arbiter sharing one synchronous-read data RAM
// between NUM_CORES cores. It returns read data to the issuing core and
// aggregates the per-core End flags into a global completion flag.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   core_req/we/end      per-core request, write select, End flag
//   core_addr/wdata      packed per-core address and write data
//   core_gnt             combinational one-hot grant
//   core_rvalid/rdata    registered read return (data is broadcast)
//   mem_en/we/addr/wdata registered RAM command; mem_rdata is the RAM output
//   last_id, all_end     last granted core, sticky all-cores-ended flag
module dram_rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    input  logic [NUM_CORES-1:0]        core_end,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [ID_W-1:0]             last_id,
    output logic                        all_end
);

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      gnt_idx;
    logic [ID_W-1:0]      ptr_next;
    logic                 gnt_any;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [NUM_CORES-1:0] end_seen;
    logic                 rd_v1;
    logic                 rd_v2;
    logic [ID_W-1:0]      rd_id1;
    logic [ID_W-1:0]      rd_id2;

    // The winner is the requester with the smallest rotating distance
    // from the pointer; its fields are selected in the same pass.
    always_comb begin
        int d;
        int best_d;
        d         = 0;
        best_d    = 0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (i >= int'(ptr)) begin
                d = i - int'(ptr);
            end else begin
                d = i + NUM_CORES - int'(ptr);
            end
            if (core_req[i] && (!gnt_any || d < best_d)) begin
                gnt_any   = 1'b1;
                best_d    = d;
                gnt_idx   = ID_W'(i);
                sel_we    = core_we[i];
                sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
        if (!rst_n) begin
            gnt_any = 1'b0;
        end
    end

    assign core_gnt = gnt_any ? (NUM_CORES'(1) << gnt_idx) : '0;

    // Explicit wrap so non-power-of-two core counts return to core 0.
    assign ptr_next = (gnt_idx == ID_W'(NUM_CORES - 1)) ?
                      '0 : gnt_idx + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            last_id     <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_v1       <= 1'b0;
            rd_v2       <= 1'b0;
            rd_id1      <= '0;
            rd_id2      <= '0;
            core_rvalid <= '0;
            core_rdata  <= '0;
            end_seen    <= '0;
            all_end     <= 1'b0;
        end else begin
            rd_v1 <= 1'b0;
            if (gnt_any) begin
                mem_en    <= 1'b1;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                last_id   <= gnt_idx;
                ptr       <= ptr_next;
                rd_v1     <= !sel_we;
                rd_id1    <= gnt_idx;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            // Stage 2 lines up with the RAM output of the read issued
            // two edges earlier.
            rd_v2  <= rd_v1;
            rd_id2 <= rd_id1;
            if (rd_v2) begin
                core_rvalid <= NUM_CORES'(1) << rd_id2;
                core_rdata  <= mem_rdata;
            end else begin
                core_rvalid <= '0;
            end
            end_seen <= end_seen | core_end;
            all_end  <= all_end | (&end_seen);
        end
    end

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// tb_dram_rr_arbiter: directed and randomized checks of dram_rr_arbiter
// against a transaction-level reference model with a shadow memory.
module tb_dram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    core_req, core_we, core_end;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata, mem_rdata, mem_wdata;
    logic            mem_en, mem_we, all_end;
    logic [AW-1:0]   mem_addr;
    logic [IW-1:0]   last_id;

    always #5 clk = ~clk;

    dram_rr_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_end(core_end), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .last_id(last_id),
        .all_end(all_end)
    );

    // Synchronous-read RAM attached to the arbiter.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 'h022) return 32'd5;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] got,
                         logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: transaction view of the arbiter.
    int            cyc = 0;
    int            m_ptr = 0;
    int            m_last = 0;
    logic          m_en = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [N-1:0]  m_rvalid = '0;
    logic [N-1:0]  seen = '0;
    int            full_cyc = -1;
    logic [DW-1:0] shadow [0:4095];
    int            due_q[$];
    int            id_q[$];
    logic [DW-1:0] dat_q[$];

    function automatic int exp_grant();
        if (!rst_n) return -1;
        for (int k = 0; k < N; k++) begin
            if (core_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        int g;
        logic [N-1:0] eg;
        @(negedge clk);
        g  = exp_grant();
        eg = (g < 0) ? '0 : (N'(1) << g);
        check("gnt", core_gnt, eg);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_ptr = 0; m_last = 0; m_en = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_rvalid = '0; seen = '0; full_cyc = -1;
            due_q.delete(); id_q.delete(); dat_q.delete();
        end else begin
            m_rvalid = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                m_rvalid = N'(1) << id_q[0];
                m_rdata  = dat_q[0];
                void'(due_q.pop_front());
                void'(id_q.pop_front());
                void'(dat_q.pop_front());
            end
            if (g >= 0) begin
                m_en    = 1;
                m_we    = core_we[g];
                m_addr  = core_addr[g*AW +: AW];
                m_wdata = core_wdata[g*DW +: DW];
                m_last  = g;
                m_ptr   = (g + 1) % N;
                if (m_we) begin
                    shadow[m_addr] = m_wdata;
                end else begin
                    due_q.push_back(cyc + 2);
                    id_q.push_back(g);
                    dat_q.push_back(shadow[m_addr]);
                end
            end else begin
                m_en = 0;
                m_we = 0;
            end
            if (full_cyc < 0) begin
                seen = seen | core_end;
                if (seen == {N{1'b1}}) full_cyc = cyc;
            end
        end
        #1;
        check("mem_en", mem_en, m_en);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("last_id", last_id, m_last);
        check("rvalid", core_rvalid, m_rvalid);
        check("rdata", core_rdata, m_rdata);
        check("all_end", all_end,
              (full_cyc >= 0 && cyc > full_cyc) ? 1 : 0);
    endtask

    task automatic set_core(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        core_addr[i*AW +: AW]  = a;
        core_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            ram[a]    <= init_val(a);
            shadow[a]  = init_val(a);
        end
        rst_n = 0; core_req = '1; core_we = '0; core_end = '0;
        core_addr = '0; core_wdata = '0;

        // Reset, then first grant goes to core 0
        tick(); tick();
        check("rst_gnt", core_gnt, 0);
        check("rst_en", mem_en, 0);
        rst_n = 1;
        tick();
        check("first_id", last_id, 0);
        core_req = '0;
        tick(); tick();

        // Single read from core 2
        set_core(2, 12'h022, 0);
        core_req = 4'b0100;
        tick();
        check("rd_addr", mem_addr, 12'h022);
        core_req = '0;
        tick();
        check("rd_early", core_rvalid, 0);
        tick();
        check("rd_valid", core_rvalid, 4'b0100);
        check("rd_data", core_rdata, 5);
        tick();
        check("rd_pulse", core_rvalid, 0);

        // Round robin from a fresh pointer
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < N; i++) set_core(i, AW'(i + 8), 0);
        core_req = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr", last_id, k % N);
        end
        core_req = '0;
        tick(); tick();

        // Write then read same address
        set_core(1, 12'h100, 32'hDEADBEEF);
        set_core(3, 12'h100, 0);
        core_req = 4'b0010; core_we = 4'b0010;
        tick();
        core_req = 4'b1000; core_we = '0;
        tick();
        core_req = '0;
        tick(); tick();
        check("wr_rd_v", core_rvalid, 4'b1000);
        check("wr_rd_d", core_rdata, 32'hDEADBEEF);

        // Reset while a read is in flight
        set_core(2, 12'h005, 0);
        core_req = 4'b0100;
        tick();
        core_req = '0; rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        check("rst_rd0", core_rvalid, 0);
        tick();
        check("rst_rd1", core_rvalid, 0);
        core_req = '1;
        tick();
        check("rst_ptr", last_id, 0);
        core_req = '0;
        tick(); tick();

        // End aggregation
        core_end = 4'b0001; tick(); core_end = '0; tick();
        core_end = 4'b0100; tick(); core_end = '0; tick();
        core_end = 4'b0010; tick(); core_end = '0; tick();
        core_end = 4'b1000; tick();
        check("end_pre", all_end, 0);
        core_end = '0;
        tick();
        check("end_set", all_end, 1);
        tick(); tick();
        check("end_hold", all_end, 1);
        rst_n = 0; tick(); rst_n = 1;
        check("end_rst", all_end, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            core_req = N'($urandom);
            core_we  = N'($urandom);
            core_end = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++)
                set_core(i, AW'($urandom_range(0, 15)), $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
